// File: rtl/hs_sink_fifo.sv
// hs_sink_fifo
// ------------
// Clocked sink for one branch of an asynchronous fork. It takes a four-phase
// bundled-data request, stores each token in a small FIFO and presents the
// tokens to clocked logic over a valid/ready interface. When the FIFO is full
// the acknowledge is held back, which stalls the upstream self-timed pipeline.
//
// Ports:
//   clk        system clock
//   rst        asynchronous, active-high reset
//   req_in     four-phase request from the fork branch (asynchronous to clk)
//   ack_in     four-phase acknowledge back to the fork branch (registered)
//   data_in    bundled data, stable while req_in is high and ack_in is low
//   data_out   FIFO head, first-word-fall-through (don't-care when !valid_out)
//   valid_out  FIFO holds at least one token
//   ready_in   consumer takes the head this cycle
//   count      current FIFO occupancy
module hs_sink_fifo #(
    parameter int WIDTH       = 8,
    parameter int DEPTH       = 4,
    parameter int SYNC_STAGES = 2
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       req_in,
    output logic                       ack_in,
    input  logic [WIDTH-1:0]           data_in,
    output logic [WIDTH-1:0]           data_out,
    output logic                       valid_out,
    input  logic                       ready_in,
    output logic [$clog2(DEPTH+1)-1:0] count
);

    localparam int AW = $clog2(DEPTH);
    localparam int CW = $clog2(DEPTH + 1);
    localparam logic [CW-1:0] FULL_C = CW'(DEPTH);

    typedef enum logic [0:0] {
        IDLE     = 1'b0,
        ACK_HIGH = 1'b1
    } state_t;

    logic [SYNC_STAGES-1:0] sync_r;
    logic                   req_s;
    state_t                 state_r;
    state_t                 state_s;
    logic                   ack_r;
    logic                   ack_s;
    logic                   push_s;
    logic                   pop_s;
    logic                   full_s;
    logic [CW-1:0]          count_r;
    logic [CW-1:0]          count_s;
    logic                   valid_r;
    logic                   valid_s;
    logic [AW-1:0]          wr_ptr_r;
    logic [AW-1:0]          rd_ptr_r;
    logic [WIDTH-1:0]       mem_r [DEPTH];

    // Request synchronizer; data_in is not synchronized because the bundling
    // constraint keeps it stable for the whole time req_s can be seen high.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            sync_r <= '0;
        end else begin
            sync_r <= {sync_r[SYNC_STAGES-2:0], req_in};
        end
    end

    assign req_s  = sync_r[SYNC_STAGES-1];

    // Full is judged on the registered occupancy, so a pop in the same cycle
    // cannot open a slot for a push until the following cycle.
    assign full_s = (count_r == FULL_C);
    assign pop_s  = valid_r & ready_in;

    // Handshake FSM: next state, next acknowledge and the write strobe.
    always_comb begin
        state_s = state_r;
        ack_s   = ack_r;
        push_s  = 1'b0;
        case (state_r)
            IDLE: begin
                if (req_s && !full_s) begin
                    push_s  = 1'b1;
                    state_s = ACK_HIGH;
                    ack_s   = 1'b1;
                end else begin
                    state_s = IDLE;
                    ack_s   = 1'b0;
                end
            end
            ACK_HIGH: begin
                // Leaving only on a low req_s makes a second capture of the
                // same token impossible.
                if (!req_s) begin
                    state_s = IDLE;
                    ack_s   = 1'b0;
                end else begin
                    state_s = ACK_HIGH;
                    ack_s   = 1'b1;
                end
            end
            default: begin
                state_s = IDLE;
                ack_s   = 1'b0;
            end
        endcase
    end

    // Next occupancy and the matching non-empty flag.
    always_comb begin
        count_s = count_r;
        case ({push_s, pop_s})
            2'b10:   count_s = count_r + CW'(1);
            2'b01:   count_s = count_r - CW'(1);
            default: count_s = count_r;
        endcase
        valid_s = (count_s != CW'(0));
    end

    // Control registers: FSM state, acknowledge, occupancy and pointers.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_r  <= IDLE;
            ack_r    <= 1'b0;
            count_r  <= '0;
            valid_r  <= 1'b0;
            wr_ptr_r <= '0;
            rd_ptr_r <= '0;
        end else begin
            state_r <= state_s;
            ack_r   <= ack_s;
            count_r <= count_s;
            valid_r <= valid_s;
            // Pointers wrap naturally because DEPTH is a power of two.
            if (push_s) begin
                wr_ptr_r <= wr_ptr_r + AW'(1);
            end
            if (pop_s) begin
                rd_ptr_r <= rd_ptr_r + AW'(1);
            end
        end
    end

    // Token storage; deliberately not reset.
    always_ff @(posedge clk) begin
        if (push_s) begin
            mem_r[wr_ptr_r] <= data_in;
        end
    end

    assign ack_in    = ack_r;
    assign valid_out = valid_r;
    assign count     = count_r;
    assign data_out  = mem_r[rd_ptr_r];

endmodule

// File: tb/tb_hs_sink_fifo.sv
// Self-checking bench for hs_sink_fifo. A token-level queue model tracks what
// the sink must hold: a token enters when the acknowledge rises, leaves when
// valid/ready are both high at a clock edge. A second instance is used for
// the fork-integration scenario.
module tb_hs_sink_fifo;

    localparam int WIDTH       = 8;
    localparam int DEPTH       = 4;
    localparam int SYNC_STAGES = 2;
    localparam int CW          = $clog2(DEPTH + 1);

    logic             clk = 1'b0;
    logic             rst;
    logic             req_in;
    logic             ack_in;
    logic [WIDTH-1:0] data_in;
    logic [WIDTH-1:0] data_out;
    logic             valid_out;
    logic             ready_in;
    logic [CW-1:0]    count;

    logic             fork_en;
    logic             ack_b;
    logic [WIDTH-1:0] data_b;
    logic             valid_b;
    logic             ready_b;
    logic [CW-1:0]    count_b;

    int               tests = 0;
    int               fails = 0;
    logic [WIDTH-1:0] exp_q[$];
    logic [WIDTH-1:0] got[$];
    logic [WIDTH-1:0] got_b[$];
    logic [WIDTH-1:0] sent[$];
    logic             prev_ack;
    bit               rand_ready;
    bit               rand_b;

    always #5 clk = ~clk;

    hs_sink_fifo #(.WIDTH(WIDTH), .DEPTH(DEPTH), .SYNC_STAGES(SYNC_STAGES)) u_dut (
        .clk(clk), .rst(rst), .req_in(req_in), .ack_in(ack_in), .data_in(data_in),
        .data_out(data_out), .valid_out(valid_out), .ready_in(ready_in), .count(count)
    );

    hs_sink_fifo #(.WIDTH(WIDTH), .DEPTH(DEPTH), .SYNC_STAGES(SYNC_STAGES)) u_b (
        .clk(clk), .rst(rst), .req_in(req_in && fork_en), .ack_in(ack_b), .data_in(data_in),
        .data_out(data_b), .valid_out(valid_b), .ready_in(ready_b), .count(count_b)
    );

    // One clock cycle: record pops before the edge, update the model, then check.
    task automatic step();
        bit pa;
        bit pb;
        pa = valid_out && ready_in;
        pb = valid_b && ready_b;
        if (pa) begin
            got.push_back(data_out);
            tests++;
            if (exp_q.size() == 0) begin
                fails++;
                $display("FAIL pop_empty: popped %0h but model is empty", data_out);
            end else begin
                if (data_out !== exp_q[0]) begin
                    fails++;
                    $display("FAIL pop_data: got %0h expected %0h", data_out, exp_q[0]);
                end
                void'(exp_q.pop_front());
            end
        end
        if (pb) got_b.push_back(data_b);
        @(posedge clk);
        #1;
        if (ack_in && !prev_ack) exp_q.push_back(data_in);
        prev_ack = ack_in;
        tests++;
        if (count !== CW'(exp_q.size()) || valid_out !== (exp_q.size() != 0)) begin
            fails++;
            $display("FAIL occupancy: count=%0d valid=%0b expected count=%0d", count, valid_out, exp_q.size());
        end
        if (rand_ready) ready_in = 1'($urandom_range(0, 1));
        if (rand_b) ready_b = 1'($urandom_range(0, 1));
    endtask

    // Full four-phase handshake with bounded waits.
    task automatic send_token(input logic [WIDTH-1:0] d);
        int n;
        data_in = d;
        req_in  = 1'b1;
        n = 0;
        while (!ack_in && n < 200) begin step(); n++; end
        tests++;
        if (!ack_in) begin fails++; $display("FAIL ack_rise_timeout: ack=%0b expected 1", ack_in); end
        req_in = 1'b0;
        n = 0;
        while (ack_in && n < 50) begin step(); n++; end
        tests++;
        if (ack_in) begin fails++; $display("FAIL ack_fall_timeout: ack=%0b expected 0", ack_in); end
    endtask

    task automatic drain();
        int n;
        rand_ready = 0;
        rand_b     = 0;
        ready_in   = 1'b1;
        ready_b    = 1'b1;
        n = 0;
        while ((valid_out || valid_b) && n < 50) begin step(); n++; end
        ready_in = 1'b0;
        ready_b  = 1'b0;
        tests++;
        if (count !== CW'(0)) begin fails++; $display("FAIL drain: count=%0d expected 0", count); end
    endtask

    task automatic test_reset();
        rst = 1'b1; req_in = 1'b0; ready_in = 1'b0; ready_b = 1'b0; fork_en = 1'b0;
        data_in = '0; rand_ready = 0; rand_b = 0;
        repeat (2) @(posedge clk);
        #1;
        tests++;
        if (ack_in !== 1'b0 || valid_out !== 1'b0 || count !== CW'(0)) begin
            fails++;
            $display("FAIL reset_state: ack=%0b valid=%0b count=%0d expected 0 0 0", ack_in, valid_out, count);
        end
        exp_q.delete(); got.delete(); got_b.delete(); sent.delete();
        prev_ack = 1'b0;
        rst = 1'b0;
        step();
        step();
    endtask

    task automatic test_single_token();
        logic [1:0] acks;
        data_in = 8'hA5;
        req_in  = 1'b1;
        step();                 // edge 0
        acks[0] = ack_in;
        step();                 // edge 1
        acks[1] = ack_in;
        tests++;
        if (acks !== 2'b00) begin fails++; $display("FAIL single_early_ack: acks=%b expected 00", acks); end
        step();                 // edge 2
        tests++;
        if (ack_in !== 1'b1 || valid_out !== 1'b1 || data_out !== 8'hA5 || count !== CW'(1)) begin
            fails++;
            $display("FAIL single_capture: ack=%0b valid=%0b data=%0h count=%0d expected 1 1 a5 1", ack_in, valid_out, data_out, count);
        end
        step(); step();         // edges 3,4
        req_in = 1'b0;
        step(); step();         // edges 5,6
        tests++;
        if (ack_in !== 1'b1) begin fails++; $display("FAIL single_ack_hold: ack=%0b expected 1", ack_in); end
        step();                 // edge 7
        tests++;
        if (ack_in !== 1'b0) begin fails++; $display("FAIL single_ack_fall: ack=%0b expected 0", ack_in); end
        ready_in = 1'b1;
        step();
        ready_in = 1'b0;
        tests++;
        if (got.size() != 1) begin fails++; $display("FAIL single_pop_count: got %0d pops expected 1", got.size()); end
    endtask

    task automatic test_fill_backpressure();
        int highs;
        int n;
        got.delete();
        ready_in = 1'b0;
        for (int i = 1; i <= 4; i++) send_token(8'(i));
        tests++;
        if (count !== CW'(4)) begin fails++; $display("FAIL fill_count: count=%0d expected 4", count); end
        data_in = 8'h05;
        req_in  = 1'b1;
        highs = 0;
        for (int i = 0; i < 20; i++) begin step(); if (ack_in) highs++; end
        tests++;
        if (highs != 0) begin fails++; $display("FAIL full_stall: ack high %0d cycles expected 0", highs); end
        ready_in = 1'b1;
        step();
        ready_in = 1'b0;
        tests++;
        if (count !== CW'(3) || data_out !== 8'h02 || ack_in !== 1'b0) begin
            fails++;
            $display("FAIL pop_while_full: count=%0d head=%0h ack=%0b expected 3 02 0", count, data_out, ack_in);
        end
        step();
        tests++;
        if (ack_in !== 1'b1 || count !== CW'(4)) begin
            fails++;
            $display("FAIL late_push: ack=%0b count=%0d expected 1 4", ack_in, count);
        end
        req_in = 1'b0;
        n = 0;
        while (ack_in && n < 20) begin step(); n++; end
        drain();
        tests++;
        if (got.size() != 5) begin
            fails++;
            $display("FAIL fill_order_len: got %0d tokens expected 5", got.size());
        end else begin
            for (int i = 0; i < 5; i++) begin
                tests++;
                if (got[i] !== 8'(i + 1)) begin fails++; $display("FAIL fill_order: got %0h expected %0h", got[i], i + 1); end
            end
        end
    endtask

    task automatic test_order_wrap();
        got.delete();
        ready_in = 1'b1;
        for (int i = 0; i < 10; i++) send_token(8'(8'h10 + i));
        repeat (3) step();
        ready_in = 1'b0;
        tests++;
        if (got.size() != 10 || count !== CW'(0)) begin
            fails++;
            $display("FAIL wrap_len: got %0d tokens count=%0d expected 10 0", got.size(), count);
        end else begin
            for (int i = 0; i < 10; i++) begin
                tests++;
                if (got[i] !== 8'(8'h10 + i)) begin fails++; $display("FAIL wrap_order: got %0h expected %0h", got[i], 8'h10 + i); end
            end
        end
    endtask

    task automatic test_simul_push_pop();
        int n;
        ready_in = 1'b0;
        send_token(8'h31);
        send_token(8'h32);
        tests++;
        if (count !== CW'(2)) begin fails++; $display("FAIL simul_setup: count=%0d expected 2", count); end
        data_in = 8'h33;
        req_in  = 1'b1;
        step(); step();
        ready_in = 1'b1;
        step();                 // capture and pop on the same edge
        ready_in = 1'b0;
        tests++;
        if (ack_in !== 1'b1 || count !== CW'(2) || data_out !== 8'h32) begin
            fails++;
            $display("FAIL simul_push_pop: ack=%0b count=%0d head=%0h expected 1 2 32", ack_in, count, data_out);
        end
        req_in = 1'b0;
        n = 0;
        while (ack_in && n < 20) begin step(); n++; end
        drain();
    endtask

    task automatic test_async_reset();
        int n;
        ready_in = 1'b0;
        send_token(8'h41);
        send_token(8'h42);
        data_in = 8'h43;
        req_in  = 1'b1;
        n = 0;
        while (!ack_in && n < 20) begin step(); n++; end
        tests++;
        if (ack_in !== 1'b1 || count !== CW'(3)) begin
            fails++;
            $display("FAIL areset_setup: ack=%0b count=%0d expected 1 3", ack_in, count);
        end
        #3;
        rst    = 1'b1;
        req_in = 1'b0;
        #1;
        tests++;
        if (ack_in !== 1'b0 || valid_out !== 1'b0 || count !== CW'(0)) begin
            fails++;
            $display("FAIL areset_immediate: ack=%0b valid=%0b count=%0d expected 0 0 0", ack_in, valid_out, count);
        end
        @(posedge clk);
        #1;
        exp_q.delete();
        prev_ack = 1'b0;
        rst = 1'b0;
        repeat (3) step();
        tests++;
        if (ack_in !== 1'b0) begin fails++; $display("FAIL areset_idle: ack=%0b expected 0", ack_in); end
        send_token(8'h77);
        tests++;
        if (count !== CW'(1) || data_out !== 8'h77) begin
            fails++;
            $display("FAIL areset_recover: count=%0d head=%0h expected 1 77", count, data_out);
        end
        drain();
    endtask

    task automatic test_random_stream();
        got.delete();
        sent.delete();
        rand_ready = 1;
        for (int i = 0; i < 30; i++) begin
            logic [WIDTH-1:0] d;
            d = 8'($urandom);
            sent.push_back(d);
            repeat ($urandom_range(0, 3)) step();
            send_token(d);
        end
        drain();
        tests++;
        if (got.size() != sent.size()) begin
            fails++;
            $display("FAIL random_len: got %0d tokens expected %0d", got.size(), sent.size());
        end else begin
            for (int i = 0; i < sent.size(); i++) begin
                tests++;
                if (got[i] !== sent[i]) begin fails++; $display("FAIL random_order: got %0h expected %0h", got[i], sent[i]); end
            end
        end
    endtask

    task automatic test_fork();
        logic fork_ack;
        int   n;
        got.delete(); got_b.delete(); sent.delete();
        fork_en    = 1'b1;
        rand_ready = 1;
        rand_b     = 1;
        fork_ack   = 1'b0;
        for (int i = 0; i < 16; i++) begin
            logic [WIDTH-1:0] d;
            d = 8'($urandom);
            sent.push_back(d);
            data_in = d;
            req_in  = 1'b1;
            n = 0;
            while (!fork_ack && n < 200) begin
                step();
                if (ack_in == ack_b) fork_ack = ack_in;
                n++;
            end
            tests++;
            if (!fork_ack || !ack_in || !ack_b) begin
                fails++;
                $display("FAIL fork_ack_rise: fork=%0b a=%0b b=%0b expected 1 1 1", fork_ack, ack_in, ack_b);
            end
            req_in = 1'b0;
            n = 0;
            while (fork_ack && n < 50) begin
                step();
                if (ack_in == ack_b) fork_ack = ack_in;
                n++;
            end
            tests++;
            if (fork_ack) begin fails++; $display("FAIL fork_ack_fall: fork=%0b expected 0", fork_ack); end
        end
        drain();
        fork_en = 1'b0;
        tests++;
        if (got.size() != sent.size() || got_b.size() != sent.size()) begin
            fails++;
            $display("FAIL fork_len: a=%0d b=%0d expected %0d", got.size(), got_b.size(), sent.size());
        end else begin
            for (int i = 0; i < sent.size(); i++) begin
                tests++;
                if (got[i] !== sent[i] || got_b[i] !== sent[i]) begin
                    fails++;
                    $display("FAIL fork_data: a=%0h b=%0h expected %0h", got[i], got_b[i], sent[i]);
                end
            end
        end
    endtask

    initial begin
        test_reset();
        test_single_token();
        test_fill_backpressure();
        test_order_wrap();
        test_simul_push_pop();
        test_async_reset();
        test_random_stream();
        test_fork();
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
